// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, pattern constants and timing defaults for the UART loopback sequencer.
package uart_pkg;
   typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_RX, S_DRAIN, S_NEXT, S_DONE} state_t;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;
   localparam int F_CLK = 50_000_000;
   localparam int FBIT = 38400;
   // twelve bit-times leaves margin over one 10-bit frame plus pipeline slack
   localparam int TO_CYC = 12 * F_CLK / FBIT;
endpackage

// File: rtl/loop_pat_gen.sv
// loop_pat_gen: test byte generator, incrementing or x^8+x^6+x^5+x^4+1 Fibonacci LFSR.
module loop_pat_gen
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       adv_i,
   input  logic       mode_i,
   input  logic [7:0] seed_i,
   output logic [7:0] dat_o
);
   logic [7:0] dat_q, dat_d;
   // an all-zero LFSR state would lock up, so a zero seed starts at 8'h01
   always_comb
      dat_d = load_i ? ((mode_i && seed_i == 8'h00) ? 8'h01 : seed_i)
            : adv_i  ? (mode_i ? {dat_q[6:0], ^(dat_q & LFSR_TAPS)} : dat_q + 8'd1)
            : dat_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dat_q <= 8'h00;
      else        dat_q <= dat_d;
   assign dat_o = dat_q;
endmodule

// File: rtl/uart_loop_seq.sv
// uart_loop_seq: handshaken loopback sequencer that sends pattern bytes, checks the echo and
// counts passes, data errors and timeouts.
module uart_loop_seq
   import uart_pkg::*;
#(
   parameter int TO_CYC = uart_pkg::TO_CYC,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [7:0]       seed,
   input  logic [7:0]       n_bytes,
   output logic             tx_st,
   output logic [7:0]       tx_dat,
   input  logic             tx_busy,
   input  logic             rx_ok,
   input  logic [7:0]       rx_dat,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] to_cnt,
   output logic [7:0]       last_bad
);
   localparam int TW = $clog2(TO_CYC + 1);
   state_t           state_q;
   logic             tx_st_q, busy_q, done_q;
   logic [7:0]       idx_q, bad_q;
   logic [TW-1:0]    tcnt_q;
   logic [CNT_W-1:0] pass_q, err_q, to_q;
   logic             load, adv, last;
   assign load = (state_q == S_IDLE || state_q == S_DONE) && start;
   assign adv  = state_q == S_NEXT;
   assign last = (n_bytes != 8'd0 && idx_q + 8'd1 == n_bytes) || stop;
   loop_pat_gen u_pat (
      .clk   (clk),
      .rst_n (rst_n),
      .load_i(load),
      .adv_i (adv),
      .mode_i(mode),
      .seed_i(seed),
      .dat_o (tx_dat)
   );
   // tx_st is registered: it is armed on the edge entering or holding SEND while the transmitter is idle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= S_IDLE;
         tx_st_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= 8'd0;
         tcnt_q  <= '0;
         pass_q  <= '0;
         err_q   <= '0;
         to_q    <= '0;
         bad_q   <= 8'd0;
      end else
         case (state_q)
            S_IDLE, S_DONE:
               if (start) begin
                  pass_q  <= '0;
                  err_q   <= '0;
                  to_q    <= '0;
                  bad_q   <= 8'd0;
                  idx_q   <= 8'd0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  tx_st_q <= !tx_busy;
                  state_q <= S_SEND;
               end
            S_SEND:
               if (tx_st_q) begin
                  tx_st_q <= 1'b0;
                  tcnt_q  <= '0;
                  state_q <= S_WAIT_RX;
               end else tx_st_q <= !tx_busy;
            S_WAIT_RX: begin
               tcnt_q <= tcnt_q + TW'(1);
               if (rx_ok) begin
                  if (rx_dat == tx_dat) pass_q <= pass_q + CNT_W'(pass_q != '1);
                  else begin
                     err_q <= err_q + CNT_W'(err_q != '1);
                     bad_q <= rx_dat;
                  end
                  state_q <= S_DRAIN;
               end else if (tcnt_q == TW'(TO_CYC - 1)) begin
                  to_q    <= to_q + CNT_W'(to_q != '1);
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN:
               if (!tx_busy) state_q <= S_NEXT;
            S_NEXT: begin
               idx_q <= idx_q + 8'd1;
               if (last) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  tx_st_q <= !tx_busy;
                  state_q <= S_SEND;
               end
            end
            default: state_q <= S_IDLE;
         endcase
   assign tx_st    = tx_st_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass_cnt = pass_q;
   assign err_cnt  = err_q;
   assign to_cnt   = to_q;
   assign last_bad = bad_q;
endmodule

// File: tb/tb_uart_loop_seq.sv
// tb_uart_loop_seq: randomized and directed checks of the loopback sequencer against an echoing UART model.
module tb_uart_loop_seq;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
   logic [7:0] seed = 8'd0, n_bytes = 8'd0, rx_dat = 8'd0;
   logic tx_busy = 1'b0, rx_ok = 1'b0;
   logic tx_st, busy, done;
   logic [7:0] tx_dat, pass_cnt, err_cnt, to_cnt, last_bad;
   int total = 0, bad = 0;
   int cyc = 0, st_cyc = 0, ecnt = 0, echo_dly = 150, busy_len = 160, corrupt_idx = -1;
   bit active = 0, echo_en = 1, corrupt_all = 0;
   logic [7:0] sent_q[$];

   uart_loop_seq #(.TO_CYC(200), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .seed(seed),
      .n_bytes(n_bytes), .tx_st(tx_st), .tx_dat(tx_dat), .tx_busy(tx_busy), .rx_ok(rx_ok),
      .rx_dat(rx_dat), .busy(busy), .done(done), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
      .to_cnt(to_cnt), .last_bad(last_bad)
   );

   always #5 clk = ~clk;

   // UART model: logs each strobed byte, stays busy busy_len cycles, echoes after echo_dly cycles
   always @(negedge clk) begin
      cyc++;
      rx_ok = 1'b0;
      if (!rst_n) begin
         active = 0;
         tx_busy = 1'b0;
      end else begin
         if (active) begin
            ecnt++;
            if (echo_en && ecnt == echo_dly && sent_q.size() > 0) begin
               rx_ok = 1'b1;
               rx_dat = corrupt_all ? ~sent_q[$] : (sent_q.size() - 1 == corrupt_idx ? 8'h5A : sent_q[$]);
            end
            tx_busy = ecnt < busy_len;
            if (ecnt >= busy_len && ecnt >= echo_dly) active = 0;
         end
         if (tx_st) begin
            sent_q.push_back(tx_dat);
            st_cyc = cyc;
            active = 1;
            ecnt = 0;
            tx_busy = 1'b1;
         end
      end
   end

   function automatic logic [7:0] pat(input logic [7:0] s, input logic m, input int i);
      logic [7:0] v;
      if (!m) return s + 8'(i);
      v = (s == 8'h00) ? 8'h01 : s;
      repeat (i) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      return v;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic go(input logic [7:0] s, input logic m, input logic [7:0] n);
      sent_q.delete();
      seed = s;
      mode = m;
      n_bytes = n;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      ok = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         tick();
         ok = done;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      total++;
      if ({tx_st, tx_dat, busy, done, pass_cnt, err_cnt, to_cnt, last_bad} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got %h want 0", {tx_st, tx_dat, busy, done, pass_cnt, err_cnt, to_cnt, last_bad});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      echo_en = 1; corrupt_all = 0; corrupt_idx = -1; echo_dly = 150; busy_len = 160;
      sent_q.delete();
      seed = 8'h10; mode = 1'b0; n_bytes = 8'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({tx_st, busy, tx_dat} !== {1'b1, 1'b1, 8'h10}) begin
         bad++;
         $display("FAIL start_latency got st=%b busy=%b dat=%h want 1 1 10", tx_st, busy, tx_dat);
      end
      wait_done(2000, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL basic_done got timeout want done"); end
      total++;
      if (sent_q.size() !== 4) begin bad++; $display("FAIL basic_count got %0d want 4", sent_q.size()); end
      for (int i = 0; i < sent_q.size(); i++) begin
         total++;
         if (sent_q[i] !== pat(8'h10, 1'b0, i)) begin
            bad++;
            $display("FAIL basic_byte%0d got %h want %h", i, sent_q[i], pat(8'h10, 1'b0, i));
         end
      end
      total++;
      if ({pass_cnt, err_cnt, to_cnt, busy} !== {8'd4, 8'd0, 8'd0, 1'b0}) begin
         bad++;
         $display("FAIL basic_counts got p=%0d e=%0d t=%0d busy=%b want 4 0 0 0", pass_cnt, err_cnt, to_cnt, busy);
      end
   endtask

   task automatic test_error();
      bit ok;
      corrupt_idx = 1;
      go(8'h20, 1'b0, 8'd3);
      wait_done(2000, ok);
      total++;
      if ({ok, pass_cnt, err_cnt, to_cnt, last_bad} !== {1'b1, 8'd2, 8'd1, 8'd0, 8'h5A}) begin
         bad++;
         $display("FAIL error_counts got ok=%b p=%0d e=%0d t=%0d lb=%h want 1 2 1 0 5a", ok, pass_cnt, err_cnt, to_cnt, last_bad);
      end
      corrupt_idx = -1;
   endtask

   task automatic test_timeout();
      bit ok;
      int seen = 0;
      logic [7:0] prev;
      echo_en = 0;
      go(8'h00, 1'b0, 8'd2);
      prev = to_cnt;
      for (int i = 0; i < 1500 && !done; i++) begin
         tick();
         if (to_cnt != prev) begin
            seen++;
            total++;
            if (cyc - st_cyc !== 201) begin
               bad++;
               $display("FAIL timeout_len got %0d want 201", cyc - st_cyc);
            end
            prev = to_cnt;
         end
      end
      wait_done(10, ok);
      total++;
      if ({ok, to_cnt, pass_cnt, 8'(seen)} !== {1'b1, 8'd2, 8'd0, 8'd2}) begin
         bad++;
         $display("FAIL timeout_counts got ok=%b t=%0d p=%0d seen=%0d want 1 2 0 2", ok, to_cnt, pass_cnt, seen);
      end
      echo_en = 1;
   endtask

   task automatic test_lfsr();
      bit ok;
      go(8'h00, 1'b1, 8'd3);
      wait_done(2000, ok);
      total++;
      if ({ok, 8'(sent_q.size()), pass_cnt} !== {1'b1, 8'd3, 8'd3}) begin
         bad++;
         $display("FAIL lfsr_run got ok=%b n=%0d p=%0d want 1 3 3", ok, sent_q.size(), pass_cnt);
      end
      for (int i = 0; i < sent_q.size(); i++) begin
         total++;
         if (sent_q[i] !== (8'h01 << i)) begin
            bad++;
            $display("FAIL lfsr_byte%0d got %h want %h", i, sent_q[i], 8'h01 << i);
         end
      end
   endtask

   task automatic test_stop();
      bit ok;
      go(8'hFE, 1'b0, 8'd0);
      for (int i = 0; i < 2000 && sent_q.size() < 3; i++) tick();
      repeat (10) tick();
      stop = 1'b1;
      wait_done(1000, ok);
      stop = 1'b0;
      total++;
      if ({ok, 8'(sent_q.size()), pass_cnt} !== {1'b1, 8'd3, 8'd3}) begin
         bad++;
         $display("FAIL stop_run got ok=%b n=%0d p=%0d want 1 3 3", ok, sent_q.size(), pass_cnt);
      end
      for (int i = 0; i < sent_q.size(); i++) begin
         total++;
         if (sent_q[i] !== pat(8'hFE, 1'b0, i)) begin
            bad++;
            $display("FAIL stop_byte%0d got %h want %h", i, sent_q[i], pat(8'hFE, 1'b0, i));
         end
      end
   endtask

   task automatic test_midrun_reset();
      bit ok;
      go(8'h33, 1'b0, 8'd4);
      for (int i = 0; i < 200 && sent_q.size() < 1; i++) tick();
      repeat (20) tick();
      rst_n = 1'b0;
      #1;
      total++;
      if ({tx_st, tx_dat, busy, done, pass_cnt, err_cnt, to_cnt, last_bad} !== '0) begin
         bad++;
         $display("FAIL midrun_reset got %h want 0", {tx_st, tx_dat, busy, done, pass_cnt, err_cnt, to_cnt, last_bad});
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      go(8'h40, 1'b0, 8'd1);
      total++;
      if ({busy, tx_dat, pass_cnt, err_cnt, to_cnt} !== {1'b1, 8'h40, 24'd0}) begin
         bad++;
         $display("FAIL restart_load got busy=%b dat=%h p=%0d e=%0d t=%0d want 1 40 0 0 0", busy, tx_dat, pass_cnt, err_cnt, to_cnt);
      end
      wait_done(1000, ok);
      total++;
      if ({ok, 8'(sent_q.size()), sent_q[0], pass_cnt} !== {1'b1, 8'd1, 8'h40, 8'd1}) begin
         bad++;
         $display("FAIL restart_run got ok=%b n=%0d b0=%h p=%0d want 1 1 40 1", ok, sent_q.size(), sent_q[0], pass_cnt);
      end
   endtask

   task automatic test_saturate();
      bit ok;
      echo_dly = 4; busy_len = 6; corrupt_all = 1;
      go(8'h00, 1'b0, 8'd0);
      for (int i = 0; i < 6000 && sent_q.size() < 260; i++) tick();
      stop = 1'b1;
      wait_done(100, ok);
      stop = 1'b0;
      total++;
      if ({ok, err_cnt, pass_cnt, last_bad} !== {1'b1, 8'hFF, 8'd0, ~sent_q[$]}) begin
         bad++;
         $display("FAIL err_saturate got ok=%b e=%h p=%0d lb=%h want 1 ff 0 %h", ok, err_cnt, pass_cnt, last_bad, ~sent_q[$]);
      end
      corrupt_all = 0; echo_dly = 150; busy_len = 160;
   endtask

   task automatic test_back_to_back();
      bit ok;
      go(8'h50, 1'b0, 8'd3);
      for (int i = 0; i < 200 && sent_q.size() < 1; i++) tick();
      seed = 8'h99;
      start = 1'b1;
      tick();
      start = 1'b0;
      seed = 8'h50;
      wait_done(2000, ok);
      total++;
      if ({ok, 8'(sent_q.size()), pass_cnt} !== {1'b1, 8'd3, 8'd3}) begin
         bad++;
         $display("FAIL busy_start got ok=%b n=%0d p=%0d want 1 3 3", ok, sent_q.size(), pass_cnt);
      end
      for (int i = 0; i < sent_q.size(); i++) begin
         total++;
         if (sent_q[i] !== pat(8'h50, 1'b0, i)) begin
            bad++;
            $display("FAIL busy_start_byte%0d got %h want %h", i, sent_q[i], pat(8'h50, 1'b0, i));
         end
      end
   endtask

   task automatic test_random();
      bit ok;
      for (int r = 0; r < 6; r++) begin
         logic [7:0] s, eb;
         logic m;
         int n, ep, ee;
         s = 8'($urandom_range(0, 255));
         m = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 5);
         echo_dly = $urandom_range(20, 80);
         busy_len = echo_dly + $urandom_range(0, 20);
         corrupt_idx = $urandom_range(0, n);
         ep = 0; ee = 0; eb = 8'h00;
         for (int i = 0; i < n; i++)
            if (i == corrupt_idx && pat(s, m, i) != 8'h5A) begin ee++; eb = 8'h5A; end
            else ep++;
         go(s, m, 8'(n));
         wait_done(400 * n, ok);
         total++;
         if ({ok, 8'(sent_q.size()), pass_cnt, err_cnt, to_cnt, last_bad} !== {1'b1, 8'(n), 8'(ep), 8'(ee), 8'd0, eb}) begin
            bad++;
            $display("FAIL rand%0d_counts got ok=%b n=%0d p=%0d e=%0d t=%0d lb=%h want 1 %0d %0d %0d 0 %h",
                     r, ok, sent_q.size(), pass_cnt, err_cnt, to_cnt, last_bad, n, ep, ee, eb);
         end
         for (int i = 0; i < sent_q.size(); i++) begin
            total++;
            if (sent_q[i] !== pat(s, m, i)) begin
               bad++;
               $display("FAIL rand%0d_byte%0d got %h want %h", r, i, sent_q[i], pat(s, m, i));
            end
         end
      end
      corrupt_idx = -1; echo_dly = 150; busy_len = 160;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_timeout();
      test_lfsr();
      test_stop();
      test_midrun_reset();
      test_saturate();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_loop_seq.md
Name: uart_loop_seq

Overview:
Loopback test sequencer for the 1-byte UART datapath. It feeds the transmitter a pattern byte, pulses its start strobe, and waits for the receiver's byte-ready strobe. It then compares the received byte against the sent byte and counts passes, data errors and timeouts. It sits between the UTXD1B start/data inputs and the URXD1B/FD8RE outputs, replacing the 1 ms free-running start strobe with a handshaken one.

Parameters:
TO_CYC, 15625, clk cycles to wait for a received byte after the start pulse; 12 bit-times at 38400 baud on a 50 MHz clock.
CNT_W, 8, width of the pass, error and timeout counters.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request; ignored while busy=1
stop  in  1  level; finish the current byte, then go to DONE
mode  in  1  0 = incrementing pattern, 1 = LFSR pattern
seed  in  8  first byte of a run
n_bytes  in  8  bytes per run; 0 = run until stop
tx_st  out  1  one-cycle start strobe to the transmitter
tx_dat  out  8  byte presented to the transmitter
tx_busy  in  1  transmitter en_tx_byte
rx_ok  in  1  receiver ok_rx_byte, one cycle
rx_dat  in  8  receiver sr_dat, valid while rx_ok=1
busy  out  1  high from start accept until DONE
done  out  1  level, high in DONE
pass_cnt  out  CNT_W  matched bytes
err_cnt  out  CNT_W  mismatched bytes
to_cnt  out  CNT_W  timed-out bytes
last_bad  out  8  rx_dat of the most recent mismatch

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: tx_st, tx_dat, busy, done, all counters, last_bad.
- States: IDLE, SEND, WAIT_RX, DRAIN, NEXT, DONE.
- IDLE/DONE + start=1: clear counters and last_bad, load tx_dat=seed, load byte index=0, busy=1, done=0. Next state is SEND.
- SEND: tx_st=1 for exactly this cycle. Clear the timeout counter. Next state is WAIT_RX.
  - If tx_busy=1 on entry to SEND, hold in SEND with tx_st=0 until tx_busy=0. The pulse is then issued in the first cycle with tx_busy=0.
- WAIT_RX: the timeout counter increments each cycle.
  - rx_ok=1 and rx_dat==tx_dat: pass_cnt+1.
  - rx_ok=1 and rx_dat!=tx_dat: err_cnt+1, last_bad=rx_dat.
  - Either rx_ok case goes to DRAIN.
  - Counter reaches TO_CYC-1 without rx_ok: to_cnt+1, go to DRAIN.
  - rx_ok in the same cycle as the timeout: rx_ok wins; no timeout is counted.
- DRAIN: wait for tx_busy=0 so the stop bit completes. Next state is NEXT.
- NEXT: index+1, and tx_dat advances to the next pattern value.
  - mode 0: tx_dat+1, wrapping 8'hFF to 8'h00.
  - mode 1: Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0. A zero seed is replaced by 8'h01 at load.
  - If (n_bytes!=0 and index+1==n_bytes) or stop=1: go to DONE. Otherwise go to SEND.
- DONE: busy=0, done=1, counters hold. start=1 begins a new run.
- All counters saturate at all-ones; they do not wrap.
- rx_ok outside WAIT_RX is ignored and nothing is counted. A spurious rx_ok in DRAIN is ignored.
- tx_dat is stable from SEND through DRAIN. It changes only in IDLE/DONE load and in NEXT.
- start while busy=1 is ignored. stop while IDLE has no effect.
- rst_n asserted mid-run: immediate return to IDLE with all outputs cleared. Any frame in flight is abandoned.
- Latency: start accepted at edge k gives tx_st high in cycle k+1 (when tx_busy=0). rx_ok at edge m gives the counter update visible at m+1.

Decomposition:
- Shared package (uart_pkg) holds:
  - the state encoding;
  - the LFSR tap mask 8'hB8;
  - the default baud and clock constants (F_CLK=50_000_000, FBIT=38400);
  - TO_CYC, derived as 12*F_CLK/FBIT.
- One sub-module, loop_pat_gen, provides next-byte generation (incrementing or LFSR) with load and advance inputs.
- The FSM, timeout counter and saturating counters stay in uart_loop_seq.

Test Plan:
- Bench TO_CYC=200, with a behavioural UART model that echoes a byte 150 cycles after tx_st. seed=8'h10, mode=0, n_bytes=4, start → tx_dat sequence 10,11,12,13; pass_cnt=4, err_cnt=0, to_cnt=0; done=1 after the 4th DRAIN.
- Echo model corrupts the 2nd byte to 8'h5A, mode=0, seed=8'h20, n_bytes=3 → pass_cnt=2, err_cnt=1, last_bad=8'h5A.
- Echo disabled, n_bytes=2 → to_cnt=2, each WAIT_RX lasting exactly 200 cycles; pass_cnt=0.
- mode=1, seed=0, n_bytes=3 → tx_dat sequence 01,02,04.
- seed=8'hFE, mode=0, n_bytes=0; assert stop during the 3rd WAIT_RX → tx_dat sequence FE,FF,00; 3rd byte completes; DONE with pass_cnt=3.
- Pulse rst_n low mid-WAIT_RX → all outputs 0 in the same cycle; a later start with seed=8'h40 restarts from 8'h40 with counters at 0.
- Additionally: force 255+ error bytes → err_cnt holds at 8'hFF.
- Additionally: start pulsed while busy → ignored; the run is unchanged.
